// File: rtl/regfile_wb_scheduler.sv
// Register file write-port scheduler: busy-bit scoreboard, load/ALU
// writeback arbitration with ALU anti-starvation, registered write stage.
//
// Ports:
//   clk_cpu, reset_n     clock, async active-low reset
//   issue_*              decode request; issue_stall holds it
//   alu_* / ld_*         writeback requesters; *_ready marks a transfer
//   wr_adrs/data/en      registered register file write port
//   busy                 scoreboard, one bit per register (bit 0 always 0)
//   wb_err               sticky: writeback hit a non-busy register
module regfile_wb_scheduler #(
   parameter int N_REGS       = 32,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk_cpu,
   input  logic              reset_n,
   input  logic              issue_valid,
   input  logic [4:0]        issue_rs,
   input  logic [4:0]        issue_rt,
   input  logic [4:0]        issue_rd,
   input  logic              issue_rd_en,
   output logic              issue_stall,
   input  logic              alu_valid,
   input  logic [4:0]        alu_adrs,
   input  logic [31:0]       alu_data,
   output logic              alu_ready,
   input  logic              ld_valid,
   input  logic [4:0]        ld_adrs,
   input  logic [31:0]       ld_data,
   output logic              ld_ready,
   output logic [4:0]        wr_adrs,
   output logic [31:0]       wr_data,
   output logic              wr_en,
   output logic [N_REGS-1:0] busy,
   output logic              wb_err
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   logic [N_REGS-1:0] busy_q, busy_d;
   logic [4:0]        wr_adrs_q, wr_adrs_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              wr_en_q, wr_en_d;
   logic              wb_err_q, wb_err_d;
   logic [CW-1:0]     starve_q, starve_d;

   logic              alu_win, ld_win, grant;
   logic [4:0]        g_adrs;
   logic [31:0]       g_data;
   logic              accept;
   logic              g_live;

   always_comb begin
      issue_stall = issue_valid &
                    (busy_q[issue_rs] | busy_q[issue_rt] |
                     (issue_rd_en & busy_q[issue_rd]));
      accept  = issue_valid & ~issue_stall & issue_rd_en &
                (issue_rd != 5'd0);
      alu_win = alu_valid & (~ld_valid | (starve_q == LIM));
      ld_win  = ld_valid & ~alu_win;
      grant   = alu_win | ld_win;
      g_adrs  = alu_win ? alu_adrs : ld_adrs;
      g_data  = alu_win ? alu_data : ld_data;
   end

   assign alu_ready = alu_win;
   assign ld_ready  = ld_win;

   // A bit being cleared by the write already in the output stage no
   // longer counts as in flight, so a second writeback to the same
   // register right behind it is flagged.
   assign g_live = busy_q[g_adrs] &
                   ~(wr_en_q & (wr_adrs_q == g_adrs));

   always_comb begin
      busy_d    = busy_q;
      wr_en_d   = 1'b0;
      wr_adrs_d = wr_adrs_q;
      wr_data_d = wr_data_q;
      wb_err_d  = wb_err_q;
      starve_d  = starve_q;

      if (wr_en_q) busy_d[wr_adrs_q] = 1'b0;
      // Set after clear so a same-edge set wins.
      if (accept) busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;

      if (grant) begin
         wr_en_d   = (g_adrs != 5'd0);
         wr_adrs_d = g_adrs;
         wr_data_d = g_data;
         if ((g_adrs != 5'd0) && !g_live) wb_err_d = 1'b1;
      end

      if (alu_win) starve_d = '0;
      else if (alu_valid && starve_q != LIM)
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk_cpu or negedge reset_n) begin
      if (!reset_n) begin
         busy_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_adrs_q <= '0;
         wr_data_q <= '0;
         wb_err_q  <= 1'b0;
         starve_q  <= '0;
      end else begin
         busy_q    <= busy_d;
         wr_en_q   <= wr_en_d;
         wr_adrs_q <= wr_adrs_d;
         wr_data_q <= wr_data_d;
         wb_err_q  <= wb_err_d;
         starve_q  <= starve_d;
      end
   end

   assign busy    = busy_q;
   assign wr_en   = wr_en_q;
   assign wr_adrs = wr_adrs_q;
   assign wr_data = wr_data_q;
   assign wb_err  = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Testbench for regfile_wb_scheduler: directed vector table, corner
// sequences, and random traffic against a behavioural model.
module tb_regfile_wb_scheduler;

   logic        clk_cpu = 1'b0;
   logic        reset_n;
   logic        issue_valid, issue_rd_en;
   logic [4:0]  issue_rs, issue_rt, issue_rd;
   logic        issue_stall;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_adrs;
   logic [31:0] alu_data;
   logic        ld_valid, ld_ready;
   logic [4:0]  ld_adrs;
   logic [31:0] ld_data;
   logic [4:0]  wr_adrs;
   logic [31:0] wr_data;
   logic        wr_en;
   logic [31:0] busy;
   logic        wb_err;

   regfile_wb_scheduler #(.N_REGS(32), .STARVE_LIMIT(3)) dut (
      .clk_cpu(clk_cpu), .reset_n(reset_n),
      .issue_valid(issue_valid), .issue_rs(issue_rs),
      .issue_rt(issue_rt), .issue_rd(issue_rd),
      .issue_rd_en(issue_rd_en), .issue_stall(issue_stall),
      .alu_valid(alu_valid), .alu_adrs(alu_adrs),
      .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_adrs(ld_adrs),
      .ld_data(ld_data), .ld_ready(ld_ready),
      .wr_adrs(wr_adrs), .wr_data(wr_data), .wr_en(wr_en),
      .busy(busy), .wb_err(wb_err)
   );

   always #5 clk_cpu = ~clk_cpu;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int LIMIT = 3;
   bit          m_busy [32];
   int          m_starve;
   bit          m_wen;
   int          m_wadr;
   logic [31:0] m_wdata;
   bit          m_err;
   bit          m_stall, m_alu_win, m_ld_win;

   function automatic logic [31:0] m_busy_vec();
      logic [31:0] v = '0;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 0;
      m_starve = 0; m_wen = 0; m_wadr = 0; m_wdata = '0; m_err = 0;
   endtask

   task automatic model_comb();
      m_stall = issue_valid && (m_busy[issue_rs] || m_busy[issue_rt] ||
                (issue_rd_en && m_busy[issue_rd]));
      m_alu_win = alu_valid && (!ld_valid || m_starve == LIMIT);
      m_ld_win  = ld_valid && !m_alu_win;
   endtask

   task automatic model_edge();
      bit          g;
      int          ga;
      logic [31:0] gd;
      bit          nb [32];
      g  = m_alu_win || m_ld_win;
      ga = m_alu_win ? int'(alu_adrs) : int'(ld_adrs);
      gd = m_alu_win ? alu_data : ld_data;
      nb = m_busy;
      if (m_wen) nb[m_wadr] = 0;
      if (issue_valid && !m_stall && issue_rd_en && issue_rd != 0)
         nb[issue_rd] = 1;
      nb[0] = 0;
      if (g && ga != 0 && !(m_busy[ga] && !(m_wen && m_wadr == ga)))
         m_err = 1;
      if (m_alu_win) m_starve = 0;
      else if (alu_valid) m_starve++;
      if (g) begin
         m_wen = (ga != 0); m_wadr = ga; m_wdata = gd;
      end else m_wen = 0;
      m_busy = nb;
   endtask

   task automatic settle();
      #2;
      model_comb();
      chk("issue_stall", 32'(issue_stall), 32'(m_stall));
      chk("alu_ready", 32'(alu_ready), 32'(m_alu_win));
      chk("ld_ready", 32'(ld_ready), 32'(m_ld_win));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk_cpu);
      #1;
      chk("wr_en", 32'(wr_en), 32'(m_wen));
      if (m_wen) begin
         chk("wr_adrs", 32'(wr_adrs), 32'(m_wadr));
         chk("wr_data", wr_data, m_wdata);
      end
      chk("busy", busy, m_busy_vec());
      chk("wb_err", 32'(wb_err), 32'(m_err));
   endtask

   task automatic idle();
      issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0;
      issue_rd_en = 0; alu_valid = 0; alu_adrs = 0; alu_data = 0;
      ld_valid = 0; ld_adrs = 0; ld_data = 0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic iv; logic [4:0] rs, rt, rd; logic en;
      logic av; logic [4:0] aa; logic [31:0] ad;
      logic lv; logic [4:0] la; logic [31:0] ldd;
      logic e_stall, e_ardy, e_lrdy, e_wen; logic [4:0] e_wadr;
      logic e_err;
   } vec_t;

   function automatic vec_t mk(
      logic iv, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
      logic en, logic av, logic [4:0] aa, logic [31:0] ad,
      logic lv, logic [4:0] la, logic [31:0] ldd,
      logic s, logic ar, logic lr, logic we, logic [4:0] wa,
      logic er);
      vec_t v;
      v.iv = iv; v.rs = rs; v.rt = rt; v.rd = rd; v.en = en;
      v.av = av; v.aa = aa; v.ad = ad;
      v.lv = lv; v.la = la; v.ldd = ldd;
      v.e_stall = s; v.e_ardy = ar; v.e_lrdy = lr;
      v.e_wen = we; v.e_wadr = wa; v.e_err = er;
      return v;
   endfunction

   vec_t tbl [20];

   bit ld_acc, alu_acc;

   initial begin
      tbl[0]  = mk(1,0,0,5,1, 0,0,0,           0,0,0,     0,0,0, 0,0,0);
      tbl[1]  = mk(1,5,0,0,0, 1,5,32'hDEADBEEF,0,0,0,     1,1,0, 1,5,0);
      tbl[2]  = mk(1,5,0,0,0, 0,0,0,           0,0,0,     1,0,0, 0,5,0);
      tbl[3]  = mk(1,5,0,0,0, 0,0,0,           0,0,0,     0,0,0, 0,5,0);
      tbl[4]  = mk(1,0,0,3,1, 0,0,0,           0,0,0,     0,0,0, 0,5,0);
      tbl[5]  = mk(1,0,0,4,1, 0,0,0,           0,0,0,     0,0,0, 0,5,0);
      tbl[6]  = mk(0,0,0,0,0, 1,4,32'h44,      1,3,32'h33,0,0,1, 1,3,0);
      tbl[7]  = mk(0,0,0,0,0, 1,4,32'h44,      0,0,0,     0,1,0, 1,4,0);
      tbl[8]  = mk(0,0,0,0,0, 0,0,0,           0,0,0,     0,0,0, 0,4,0);
      tbl[9]  = mk(1,0,0,7,1, 0,0,0,           0,0,0,     0,0,0, 0,4,0);
      tbl[10] = mk(0,0,0,0,0, 1,7,32'h77,      1,0,32'h11,0,0,1, 0,0,0);
      tbl[11] = mk(0,0,0,0,0, 1,7,32'h77,      1,0,32'h11,0,0,1, 0,0,0);
      tbl[12] = mk(0,0,0,0,0, 1,7,32'h77,      1,0,32'h11,0,0,1, 0,0,0);
      tbl[13] = mk(0,0,0,0,0, 1,7,32'h77,      1,0,32'h11,0,1,0, 1,7,0);
      tbl[14] = mk(0,0,0,0,0, 0,0,0,           0,0,0,     0,0,0, 0,7,0);
      tbl[15] = mk(0,0,0,0,0, 1,0,32'h99,      0,0,0,     0,1,0, 0,0,0);
      tbl[16] = mk(0,0,0,0,0, 1,9,32'h99,      0,0,0,     0,1,0, 1,9,1);
      tbl[17] = mk(1,0,0,2,1, 0,0,0,           0,0,0,     0,0,0, 0,9,1);
      tbl[18] = mk(1,0,0,2,1, 0,0,0,           0,0,0,     1,0,0, 0,9,1);
      tbl[19] = mk(1,0,0,0,1, 0,0,0,           0,0,0,     0,0,0, 0,9,1);

      idle();
      reset_n = 0;
      model_reset();
      #12;
      chk("rst busy", busy, 32'h0);
      chk("rst wr_en", 32'(wr_en), 32'h0);
      chk("rst wb_err", 32'(wb_err), 32'h0);
      chk("rst wr_adrs", 32'(wr_adrs), 32'h0);
      chk("rst wr_data", wr_data, 32'h0);
      @(posedge clk_cpu); #1;
      reset_n = 1;

      foreach (tbl[i]) begin
         issue_valid = tbl[i].iv; issue_rs = tbl[i].rs;
         issue_rt = tbl[i].rt; issue_rd = tbl[i].rd;
         issue_rd_en = tbl[i].en;
         alu_valid = tbl[i].av; alu_adrs = tbl[i].aa;
         alu_data = tbl[i].ad;
         ld_valid = tbl[i].lv; ld_adrs = tbl[i].la;
         ld_data = tbl[i].ldd;
         settle();
         chk($sformatf("tbl%0d stall", i), 32'(issue_stall),
             32'(tbl[i].e_stall));
         chk($sformatf("tbl%0d alu_rdy", i), 32'(alu_ready),
             32'(tbl[i].e_ardy));
         chk($sformatf("tbl%0d ld_rdy", i), 32'(ld_ready),
             32'(tbl[i].e_lrdy));
         tick();
         chk($sformatf("tbl%0d wr_en", i), 32'(wr_en),
             32'(tbl[i].e_wen));
         chk($sformatf("tbl%0d wr_adrs", i), 32'(wr_adrs),
             32'(tbl[i].e_wadr));
         chk($sformatf("tbl%0d wb_err", i), 32'(wb_err),
             32'(tbl[i].e_err));
         if (i == 1) chk("tbl1 wr_data", wr_data, 32'hDEADBEEF);
      end
      chk("tbl end busy", busy, 32'h0000_0004);

      // Reset asserted while a write sits in the output stage.
      idle();
      issue_valid = 1; issue_rd = 6; issue_rd_en = 1;
      settle(); tick();
      idle();
      alu_valid = 1; alu_adrs = 6; alu_data = 32'h600D;
      settle(); tick();
      chk("pre-rst wr_en", 32'(wr_en), 32'h1);
      idle();
      #2 reset_n = 0;
      #1;
      chk("midrst wr_en", 32'(wr_en), 32'h0);
      chk("midrst busy", busy, 32'h0);
      chk("midrst wb_err", 32'(wb_err), 32'h0);
      model_reset();
      @(posedge clk_cpu); #1;
      reset_n = 1;

      // Load and ALU both target register 8 in the same cycle.
      issue_valid = 1; issue_rd = 8; issue_rd_en = 1;
      settle(); tick();
      idle();
      ld_valid = 1; ld_adrs = 8; ld_data = 32'h88;
      alu_valid = 1; alu_adrs = 8; alu_data = 32'h8A;
      settle();
      chk("dup ld_rdy", 32'(ld_ready), 32'h1);
      chk("dup alu_rdy", 32'(alu_ready), 32'h0);
      tick();
      chk("dup first err", 32'(wb_err), 32'h0);
      ld_valid = 0;
      settle();
      chk("dup alu_rdy2", 32'(alu_ready), 32'h1);
      tick();
      chk("dup second wr", wr_data, 32'h8A);
      chk("dup second err", 32'(wb_err), 32'h1);

      // Random traffic; requesters hold until accepted.
      idle();
      reset_n = 0;
      model_reset();
      @(posedge clk_cpu); #1;
      reset_n = 1;
      ld_acc = 1; alu_acc = 1;
      for (int c = 0; c < 400; c++) begin
         issue_valid = ($urandom_range(0, 2) != 0);
         issue_rs = 5'($urandom_range(0, 15));
         issue_rt = 5'($urandom_range(0, 15));
         issue_rd = 5'($urandom_range(0, 15));
         issue_rd_en = $urandom_range(0, 1) == 1;
         if (!ld_valid || ld_acc) begin
            ld_valid = ($urandom_range(0, 2) == 0);
            ld_adrs = 5'($urandom_range(0, 15));
            ld_data = $urandom;
         end
         if (!alu_valid || alu_acc) begin
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_adrs = 5'($urandom_range(0, 15));
            alu_data = $urandom;
         end
         settle();
         ld_acc = ld_ready;
         alu_acc = alu_ready;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
